lms_weight_update: RTL and testbench
====================================

# lms_weight_update

Sequential LMS tap-weight updater for the adaptive filter. It holds the input-sample delay line and the tap weights. It consumes the error term produced by the error subtractor and walks the taps one per cycle, applying W[k] <= sat(W[k] + ((E*x[k]) >>> (DW-1+MU_SHIFT))). It sits at the feedback end of the filter loop and closes the path from the error back to the FIR coefficients.

## Interface
- TAPS, 4, number of filter taps (≥2)
- DW, 10, sample and error width, signed two's complement
- WW, 10, weight width, signed two's complement
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- X  in  DW  new input sample
- X_valid  in  1  X present
- X_ready  out  1  sample accepted when X_valid & X_ready
- E  in  DW  error term (desired − filter output)
- E_valid  in  1  E present
- E_ready  out  1  error accepted when E_valid & E_ready
- BUSY  out  1  update sweep in progress
- DONE  out  1  one-cycle pulse, all taps updated
- W_flat  out  TAPS*WW  weights, tap k at [k*WW +: WW]
- X_flat  out  TAPS*DW  delay line, x[0] newest, feeds the FIR

## Operation
- States:
  - IDLE: accepts X or E.
  - UPDATE: tap index k = 0..TAPS-1, one tap per cycle.
  - DONE: one cycle, then IDLE.
- IDLE + E accepted: latch E and set k=0 -> UPDATE.
- UPDATE: write tap k; if k=TAPS-1 -> DONE, else k+1.
- X accepted in IDLE: x[i] <= x[i-1] for i ≥ 1; x[0] <= X. There is no effect in other states.
- E_ready = (state==IDLE).
- X_ready = (state==IDLE) & ~E_valid. E has priority: on simultaneous valids the error is taken first and the sample waits.
- Delay line and E are frozen during UPDATE and DONE. The sweep always uses the samples present at E acceptance.
- Arithmetic per tap:
  - prod = E*x[k], 2*DW-bit signed.
  - delta = prod >>> (DW-1+MU_SHIFT), arithmetic shift. This truncates toward −inf with no rounding.
  - sum = W[k] + delta, evaluated at WW+1 bits.
  - Saturate sum to [−2^(WW-1), 2^(WW-1)−1], i.e. [−512, 511] at defaults. Overflow never wraps.
- BUSY = (state==UPDATE).
- DONE = (state==DONE).

## Timing
- Reset values: state IDLE, all weights 0, all delay-line entries 0, E register 0, k 0, BUSY 0, DONE 0, E_ready 1, X_ready 1 (when E_valid low).
- Reset is asynchronous mid-sweep. Weights return to 0, and partially updated taps are not retained.
- Sweep timing, with E accepted at edge 0:
  - Tap k is updated at edge k+1.
  - DONE is high in the cycle after edge TAPS.
  - IDLE resumes at edge TAPS+1.
- Minimum spacing between accepted errors is TAPS+2 cycles (6 at defaults).
- W_flat and X_flat are registered outputs. A new weight is visible the cycle after its write edge.
- Holding E_valid high keeps the block in back-to-back sweeps. X is starved until E_valid drops, and the bench must respect this.

## Structure
- Shared package lms_pkg holds:
  - DW, WW, MU_SHIFT defaults
  - state encoding constants IDLE/UPDATE/DONE
  - saturation bounds WMAX/WMIN
- One sub-module, sat_add, is natural. It takes (WW-bit a, WW+1-bit delta) and returns the saturated WW-bit sum.
- Only one sat_add and one multiplier are instantiated, shared across taps via the k mux.

## Test plan
- Reset check: after reset, W_flat=0, X_flat=0, DONE=0, E_ready=1.
- Basic update: shift in four samples X=256, then E=256. prod=65536 gives delta=8, so all weights are 8. DONE pulses exactly at cycle 5 after acceptance.
- Negative truncation: x[0]=1 (others 0), E=−1. delta=−1 gives W[0]=−1 and W[1..3] unchanged, which confirms floor rather than round-to-zero.
- Saturation: x=511 in all taps, E=511 repeatedly. Each sweep gives delta=31. After 16 sweeps W=496; the 17th sweep gives W=511 (not 527), and further sweeps hold at 511. The mirror case (E=−512, x=511) clamps at −512.
- Priority: X_valid and E_valid asserted in the same IDLE cycle. E is accepted and X_ready=0. X is accepted at the first IDLE cycle after DONE, and the sweep used the old delay line.
- Reset mid-sweep: drop rst_n during UPDATE at k=2. All weights read 0 immediately, state is IDLE, DONE never pulses.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared definitions for the LMS tap-weight updater: default widths,
// sweep state encoding and the weight saturation bounds.
package lms_pkg;

    localparam int TAPS_DEF     = 4;
    localparam int DW_DEF       = 10;
    localparam int WW_DEF       = 10;
    localparam int MU_SHIFT_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Weight range at the default weight width.
    localparam int WMAX = (2 ** (WW_DEF - 1)) - 1;
    localparam int WMIN = -(2 ** (WW_DEF - 1));

endpackage

// File: rtl/lms_weight_update_sat_add.sv
// Saturating adder: WW-bit weight plus (WW+1)-bit correction, clamped to
// the WW-bit two's complement range so an overflowing update never wraps.
module sat_add
    import lms_pkg::*;
#(
    parameter int WW = WW_DEF
)(
    input  logic signed [WW-1:0] a,
    input  logic signed [WW:0]   delta,
    output logic signed [WW-1:0] y
);

    localparam logic signed [WW+1:0] SMAX = (WW+2)'((2 ** (WW - 1)) - 1);
    localparam logic signed [WW+1:0] SMIN = (WW+2)'(-(2 ** (WW - 1)));

    function automatic logic signed [WW-1:0] sat(input logic signed [WW+1:0] s);
        if (s > SMAX) begin
            return SMAX[WW-1:0];
        end else if (s < SMIN) begin
            return SMIN[WW-1:0];
        end else begin
            return s[WW-1:0];
        end
    endfunction

    // Two guard bits hold any weight + correction sum without overflow.
    logic signed [WW+1:0] sum;

    assign sum = (WW+2)'(a) + (WW+2)'(delta);
    assign y   = sat(sum);

endmodule

// File: rtl/lms_weight_update.sv
// Sequential LMS weight updater. Holds the input delay line and the tap
// weights; each accepted error launches a sweep that updates one tap per
// cycle through a single shared multiplier and saturating adder.
module lms_weight_update
    import lms_pkg::*;
#(
    parameter int TAPS     = TAPS_DEF,
    parameter int DW       = DW_DEF,
    parameter int WW       = WW_DEF,
    parameter int MU_SHIFT = MU_SHIFT_DEF
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] X,
    input  logic                 X_valid,
    output logic                 X_ready,
    input  logic signed [DW-1:0] E,
    input  logic                 E_valid,
    output logic                 E_ready,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [TAPS*WW-1:0]   W_flat,
    output logic [TAPS*DW-1:0]   X_flat
);

    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int SH = DW - 1 + MU_SHIFT;
    localparam int PW = (2 * DW > WW + 1) ? 2 * DW : WW + 1;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
    localparam logic signed [PW-1:0] DMAX = PW'((2 ** WW) - 1);
    localparam logic signed [PW-1:0] DMIN = PW'(-(2 ** WW));

    // Clamping the shifted product to WW+1 bits cannot change the final
    // saturated weight: any larger magnitude already drives the sum past
    // the weight range in the same direction.
    function automatic logic signed [WW:0] sat_delta(input logic signed [PW-1:0] d);
        if (d > DMAX) begin
            return DMAX[WW:0];
        end else if (d < DMIN) begin
            return DMIN[WW:0];
        end else begin
            return d[WW:0];
        end
    endfunction

    state_t                state, state_nxt;
    logic [KW-1:0]         k;
    logic signed [DW-1:0]  e_reg;
    logic signed [DW-1:0]  x_line [TAPS];
    logic signed [WW-1:0]  w      [TAPS];
    logic                  e_acc, x_acc;
    logic signed [DW-1:0]  x_k;
    logic signed [2*DW-1:0] prod;
    logic signed [PW-1:0]  delta_full;
    logic signed [WW:0]    delta;
    logic signed [WW-1:0]  w_new;

    assign E_ready = (state == S_IDLE);
    assign X_ready = (state == S_IDLE) & ~E_valid;
    assign e_acc   = E_valid & E_ready;
    assign x_acc   = X_valid & X_ready;
    assign BUSY    = (state == S_UPDATE);
    assign DONE    = (state == S_DONE);

    // Shared datapath: tap k selected, product shifted (floor), clamped.
    assign x_k        = x_line[k];
    assign prod       = (2*DW)'(e_reg) * (2*DW)'(x_k);
    assign delta_full = PW'(prod) >>> SH;
    assign delta      = sat_delta(delta_full);

    sat_add #(.WW(WW)) u_sat_add (
        .a     (w[k]),
        .delta (delta),
        .y     (w_new)
    );

    // Sweep state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: error starts a sweep, last tap ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (E_valid) state_nxt = S_UPDATE;
            S_UPDATE: if (k == K_LAST) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Error latch and tap index; both frozen outside their load points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_reg <= '0;
            k     <= '0;
        end else if (e_acc) begin
            e_reg <= E;
            k     <= '0;
        end else if (state == S_UPDATE && k != K_LAST) begin
            k     <= k + 1'b1;
        end
    end

    // Input delay line, shifted only on an accepted sample in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) x_line[i] <= '0;
        end else if (x_acc) begin
            for (int i = TAPS - 1; i > 0; i--) x_line[i] <= x_line[i-1];
            x_line[0] <= X;
        end
    end

    // Tap weights, one written per UPDATE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
        end else if (state == S_UPDATE) begin
            w[k] <= w_new;
        end
    end

    // Flatten the register arrays onto the output buses.
    always_comb begin
        W_flat = '0;
        X_flat = '0;
        for (int i = 0; i < TAPS; i++) begin
            W_flat[i*WW +: WW] = w[i];
            X_flat[i*DW +: DW] = x_line[i];
        end
    end

endmodule

// File: tb/tb_lms_weight_update.sv
// Scoreboard bench for lms_weight_update: each accepted error pushes the
// hand-computed weights expected at the end of its sweep; a monitor pops
// and compares whenever DONE is presented.
module tb_lms_weight_update;
    import lms_pkg::*;

    localparam int TAPS = 4;
    localparam int DW   = 10;
    localparam int WW   = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     X = '0;
    logic              X_valid = 1'b0;
    logic              X_ready;
    logic [DW-1:0]     E = '0;
    logic              E_valid = 1'b0;
    logic              E_ready;
    logic              BUSY;
    logic              DONE;
    logic [TAPS*WW-1:0] W_flat;
    logic [TAPS*DW-1:0] X_flat;

    lms_weight_update #(.TAPS(TAPS), .DW(DW), .WW(WW), .MU_SHIFT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .X       (X),
        .X_valid (X_valid),
        .X_ready (X_ready),
        .E       (E),
        .E_valid (E_valid),
        .E_ready (E_ready),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .W_flat  (W_flat),
        .X_flat  (X_flat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TAPS*WW-1:0] w;
        int                 acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [TAPS*WW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {WW'(d), WW'(c), WW'(b), WW'(a)};
    endfunction

    function automatic int wtap(input logic [TAPS*WW-1:0] v, input int k);
        return int'($signed(v[k*WW +: WW]));
    endfunction

    function automatic int xtap(input logic [TAPS*DW-1:0] v, input int k);
        return int'($signed(v[k*DW +: DW]));
    endfunction

    // Monitor: every DONE pulse must match the oldest outstanding sweep.
    exp_t ex;
    always @(negedge clk) begin
        if (rst_n && DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                ex = sb.pop_front();
                chk("done_latency", cyc - ex.acc, TAPS);
                for (int k = 0; k < TAPS; k++)
                    chk($sformatf("sweep_w%0d", k), wtap(W_flat, k), wtap(ex.w, k));
            end
        end
    end

    task automatic send_x(input int v);
        int n;
        n = 0;
        @(negedge clk);
        X = DW'(v);
        X_valid = 1'b1;
        while (!X_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!X_ready) chk("x_handshake_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
        X_valid = 1'b0;
    endtask

    // Returns the cycle stamp of the accepting edge.
    task automatic send_e(input int v, input logic [TAPS*WW-1:0] ew, input bit push, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        E = DW'(v);
        E_valid = 1'b1;
        while (!E_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!E_ready) begin
            chk("e_handshake_timeout", 0, 1);
            E_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            E_valid = 1'b0;
            acc = cyc;
            if (push) sb.push_back('{ew, acc});
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic reset_pulse();
        wait_drain();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int a;
    int v;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_w_flat_zero", int'(W_flat == '0), 1);
        chk("rst_x_flat_zero", int'(X_flat == '0), 1);
        chk("rst_done", DONE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_e_ready", E_ready, 1);
        chk("rst_x_ready", X_ready, 1);

        // Basic update: x = 256 everywhere, E = 256 -> delta 8
        repeat (4) send_x(256);
        for (int k = 0; k < TAPS; k++) chk($sformatf("basic_x%0d", k), xtap(X_flat, k), 256);
        send_e(256, pack4(8, 8, 8, 8), 1'b1, a);
        chk("basic_busy", BUSY, 1);
        chk("basic_x_ready_busy", X_ready, 0);
        @(negedge clk);
        chk("basic_w0_before_edge1", wtap(W_flat, 0), 0);
        @(negedge clk);
        chk("basic_w0_after_edge1", wtap(W_flat, 0), 8);
        chk("basic_w1_after_edge1", wtap(W_flat, 1), 0);

        // Negative truncation: 1 * -1 >>> 13 floors to -1
        reset_pulse();
        send_x(1);
        send_e(-1, pack4(-1, 0, 0, 0), 1'b1, a);

        // Positive saturation: delta 31 per sweep, clamp at 511
        reset_pulse();
        repeat (4) send_x(511);
        for (int n = 1; n <= 18; n++) begin
            v = (31 * n > WMAX) ? WMAX : 31 * n;
            send_e(511, pack4(v, v, v, v), 1'b1, a);
        end

        // Negative saturation: delta -32 per sweep, clamp at -512
        reset_pulse();
        repeat (4) send_x(511);
        for (int n = 1; n <= 17; n++) begin
            v = (-32 * n < WMIN) ? WMIN : -32 * n;
            send_e(-512, pack4(v, v, v, v), 1'b1, a);
        end

        // Priority: simultaneous X and E, E wins, sweep uses old line
        reset_pulse();
        send_x(64);
        @(negedge clk);
        X = DW'(200);
        X_valid = 1'b1;
        E = DW'(128);
        E_valid = 1'b1;
        #1;
        chk("prio_x_ready", X_ready, 0);
        chk("prio_e_ready", E_ready, 1);
        @(posedge clk);
        #1;
        E_valid = 1'b0;
        a = cyc;
        sb.push_back('{pack4(1, 0, 0, 0), a});
        @(negedge clk);
        chk("prio_x_ready_busy", X_ready, 0);
        chk("prio_x0_frozen", xtap(X_flat, 0), 64);
        begin
            int n;
            n = 0;
            while (!X_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!X_ready) chk("prio_x_timeout", 0, 1);
            else begin
                @(posedge clk);
                #1;
                chk("prio_x_accept_cycle", cyc - a, TAPS + 2);
            end
        end
        X_valid = 1'b0;
        chk("prio_x0_new", xtap(X_flat, 0), 200);
        chk("prio_x1_old", xtap(X_flat, 1), 64);

        // Reset mid-sweep at k = 2
        reset_pulse();
        repeat (4) send_x(256);
        send_e(256, '0, 1'b0, a);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midrst_w0_pre", wtap(W_flat, 0), 8);
        chk("midrst_w1_pre", wtap(W_flat, 1), 8);
        chk("midrst_w2_pre", wtap(W_flat, 2), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_w_zero", int'(W_flat == '0), 1);
        chk("midrst_x_zero", int'(X_flat == '0), 1);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_e_ready", E_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_w_still_zero", int'(W_flat == '0), 1);

        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
